acq_wnd_gen: RTL and testbench
==============================

// Module: acq_wnd_gen
// PURPOSE
//  Source side of the ACQ_WND interface. Generates a train of NUM_ECHOES acquisition windows, one per echo period, after a START pulse.
//  Drives ACQ_WND into the ADC window generator, which edge-detects each rising edge to open its ACQ_EN window.
//  Sits between the pulse-sequencer control registers and the ADC acquisition path.
// PARAMETERS
//  DATABUS_WIDTH  32  width of all timing/count inputs and internal counters
// PORTS
//  CLK          in   1    system clock
//  RESET        in   1    reset, asynchronous, active-high
//  START        in   1    level; sampled each CLK edge, accepted only in IDLE
//  ECHO_PERIOD  in   DW   echo period in CLK cycles (>=2)
//  WND_DELAY    in   DW   cycles from echo origin to ACQ_WND rise (>=0)
//  WND_WIDTH    in   DW   ACQ_WND high time in cycles (>=1)
//  NUM_ECHOES   in   DW   number of windows per run (>=1)
//  ACQ_WND      out  1    acquisition window, registered
//  BUSY         out  1    high from accepted START until run ends
//  DONE         out  1    one-cycle pulse at normal run completion
//  CFG_ERR      out  1    one-cycle pulse: START rejected, illegal config
//  ECHO_IDX     out  DW   index of current echo, 0..NUM_ECHOES-1
// BEHAVIOUR
//  - Reset values: ACQ_WND=0, BUSY=0, DONE=0, CFG_ERR=0, ECHO_IDX=0, state=IDLE, counters=0; effect immediate (async), also mid-run.
//  - States: IDLE, PRE (delay), WND (window high), POST (rest of period), FIN.
//  - IDLE: on edge E0 with START=1, check legality: NUM_ECHOES!=0, WND_WIDTH!=0,
//    WND_DELAY+WND_WIDTH < ECHO_PERIOD (sum computed in DW+1 bits, no wrap).
//    Illegal -> CFG_ERR=1 for one cycle, stay IDLE, BUSY stays 0.
//    Legal -> latch all four config inputs, BUSY<=1, ECHO_IDX<=0, period cnt<=0; go PRE (or WND if WND_DELAY==0).
//  - Config inputs changing while BUSY have no effect (latched copies used).
//  - Timing, echo k (0-based), origin Ok = E0 + k*ECHO_PERIOD:
//    ACQ_WND rises on edge Ok+WND_DELAY+1, falls on edge Ok+WND_DELAY+WND_WIDTH+1.
//    Window is exactly WND_WIDTH cycles; low gap between windows >= 1 cycle (guaranteed by legality rule).
//  - ECHO_IDX increments on edge Ok+ECHO_PERIOD for k < NUM_ECHOES-1.
//  - Completion on edge E0+NUM_ECHOES*ECHO_PERIOD: BUSY<=0, DONE<=1 for one cycle (FIN), ECHO_IDX holds last value, return IDLE.
//  - A START sampled on the DONE cycle is accepted (back-to-back runs); START while BUSY is ignored (no error).
//  - START held high continuously retriggers each time IDLE is reached.
//  - Counters are DW-bit up-counters compared to latched values; no overflow possible under legal config.
// CONFIGURATION
//  ACQ_WND_GEN_ABORT_EN defined: adds input ABORT (1 bit, level). ABORT=1 sampled while BUSY -> next edge ACQ_WND<=0, BUSY<=0, ECHO_IDX<=0, state IDLE, no DONE pulse.
//    ABORT has priority over START in the same cycle; ABORT in IDLE has no effect.
//  ACQ_WND_GEN_ABORT_EN not defined: ABORT port and logic absent; a run always completes or is cleared only by RESET.
// TESTING
//  1. PERIOD=10,DELAY=3,WIDTH=4,ECHOES=3, START at E0 -> ACQ_WND high edges E0+4..E0+8, E0+14..E0+18, E0+24..E0+28; DONE at E0+30; BUSY 30 cycles.
//  2. DELAY=0,WIDTH=1,PERIOD=2,ECHOES=4 -> ACQ_WND toggles 1/0 from E0+1, 4 pulses, DONE at E0+8.
//  3. DELAY=5,WIDTH=5,PERIOD=10 -> CFG_ERR pulse, BUSY=0, ACQ_WND=0; likewise ECHOES=0 and WIDTH=0.
//  4. START re-pulsed at E0+7 and inputs changed mid-run -> waveform identical to test 1; START on DONE cycle starts second run at once.
//  5. RESET asserted during ACQ_WND high (E0+6 of test 1) -> all outputs 0 asynchronously; next START runs normally from echo 0.
//  6. (ACQ_WND_GEN_ABORT_EN) ABORT at E0+15 of test 1 -> ACQ_WND 0 at E0+16, BUSY 0, no DONE; ABORT+START together while BUSY -> abort wins.

Source files
------------

// File: rtl/acq_wnd_if.sv
// ACQ_WND control/status bundle between the pulse-sequencer registers and the window generator.
// ABORT is present only when ACQ_WND_GEN_ABORT_EN is defined.
interface acq_wnd_if #(
    parameter int unsigned DATABUS_WIDTH = 32
);
    localparam int unsigned DW = DATABUS_WIDTH;

    logic          START;
    logic [DW-1:0] ECHO_PERIOD;
    logic [DW-1:0] WND_DELAY;
    logic [DW-1:0] WND_WIDTH;
    logic [DW-1:0] NUM_ECHOES;
`ifdef ACQ_WND_GEN_ABORT_EN
    logic          ABORT;
`endif
    logic          ACQ_WND;
    logic          BUSY;
    logic          DONE;
    logic          CFG_ERR;
    logic [DW-1:0] ECHO_IDX;

    modport master (
        output START, ECHO_PERIOD, WND_DELAY, WND_WIDTH, NUM_ECHOES,
`ifdef ACQ_WND_GEN_ABORT_EN
        output ABORT,
`endif
        input  ACQ_WND, BUSY, DONE, CFG_ERR, ECHO_IDX
    );

    modport slave (
        input  START, ECHO_PERIOD, WND_DELAY, WND_WIDTH, NUM_ECHOES,
`ifdef ACQ_WND_GEN_ABORT_EN
        input  ABORT,
`endif
        output ACQ_WND, BUSY, DONE, CFG_ERR, ECHO_IDX
    );
endinterface

// File: rtl/acq_wnd_gen.sv
// acq_wnd_gen: generates NUM_ECHOES acquisition windows, one per echo period, after START.
// Define ACQ_WND_GEN_ABORT_EN to add the ABORT input that cancels a run in progress.
module acq_wnd_gen #(
    parameter int unsigned DATABUS_WIDTH = 32
) (
    input logic      CLK,
    input logic      RESET,
    acq_wnd_if.slave bus
);
    localparam int unsigned DW = DATABUS_WIDTH;

    typedef enum logic [2:0] {IDLE, PRE, WND, POST, FIN} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] per_q, per_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [DW-1:0] wid_q, wid_d;
    logic [DW-1:0] num_q, num_d;
    logic [DW-1:0] pcnt_q, pcnt_d;
    logic [DW-1:0] echo_idx_q, echo_idx_d;
    logic          acq_wnd_q, acq_wnd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cfg_err_q, cfg_err_d;

    logic          cfg_ok;
    logic          abort;

    // Phase of the echo period for count t: before, inside, or after the window slot.
    function automatic state_t phase_of(input logic [DW-1:0] t,
                                        input logic [DW-1:0] d,
                                        input logic [DW-1:0] w);
        logic [DW:0] wnd_end;
        wnd_end = (DW+1)'(d) + (DW+1)'(w);
        if (t < d)
            return PRE;
        else if ((DW+1)'(t) < wnd_end)
            return WND;
        return POST;
    endfunction

    // Extra bit on the sum so huge delays cannot wrap into a false pass.
    assign cfg_ok = (bus.NUM_ECHOES != '0) && (bus.WND_WIDTH != '0) &&
                    (((DW+1)'(bus.WND_DELAY) + (DW+1)'(bus.WND_WIDTH)) <
                     (DW+1)'(bus.ECHO_PERIOD));

`ifdef ACQ_WND_GEN_ABORT_EN
    assign abort = bus.ABORT;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        per_d      = per_q;
        dly_d      = dly_q;
        wid_d      = wid_q;
        num_d      = num_q;
        pcnt_d     = pcnt_q;
        echo_idx_d = echo_idx_q;
        acq_wnd_d  = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;

        case (state_q)
            // FIN behaves as IDLE so a START on the DONE cycle launches the next run.
            IDLE, FIN: begin
                state_d = IDLE;
                if (bus.START) begin
                    if (cfg_ok) begin
                        per_d      = bus.ECHO_PERIOD;
                        dly_d      = bus.WND_DELAY;
                        wid_d      = bus.WND_WIDTH;
                        num_d      = bus.NUM_ECHOES;
                        pcnt_d     = '0;
                        echo_idx_d = '0;
                        busy_d     = 1'b1;
                        state_d    = phase_of('0, bus.WND_DELAY, bus.WND_WIDTH);
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            PRE, WND, POST: begin
                if (abort) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    echo_idx_d = '0;
                    pcnt_d     = '0;
                end else begin
                    // Output trails the phase by one edge: WND at count t means high after t+1.
                    acq_wnd_d = (state_q == WND);
                    if (pcnt_q == per_q - DW'(1)) begin
                        pcnt_d = '0;
                        if (echo_idx_q == num_q - DW'(1)) begin
                            state_d = FIN;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            echo_idx_d = echo_idx_q + DW'(1);
                            state_d    = phase_of('0, dly_q, wid_q);
                        end
                    end else begin
                        pcnt_d  = pcnt_q + DW'(1);
                        state_d = phase_of(pcnt_q + DW'(1), dly_q, wid_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            per_q      <= '0;
            dly_q      <= '0;
            wid_q      <= '0;
            num_q      <= '0;
            pcnt_q     <= '0;
            echo_idx_q <= '0;
            acq_wnd_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_q      <= per_d;
            dly_q      <= dly_d;
            wid_q      <= wid_d;
            num_q      <= num_d;
            pcnt_q     <= pcnt_d;
            echo_idx_q <= echo_idx_d;
            acq_wnd_q  <= acq_wnd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign bus.ACQ_WND  = acq_wnd_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.CFG_ERR  = cfg_err_q;
    assign bus.ECHO_IDX = echo_idx_q;
endmodule

// File: tb/tb_acq_wnd_gen.sv
// Self-checking bench for acq_wnd_gen: directed cases plus randomized runs against a timing model.
module tb_acq_wnd_gen;
    localparam int unsigned DW = 32;

    logic CLK = 1'b0;
    logic RESET;

    acq_wnd_if #(.DATABUS_WIDTH(DW)) bus ();

    acq_wnd_gen #(.DATABUS_WIDTH(DW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int last_idx = 0;

    logic [35:0] obs;
    assign obs = {bus.ACQ_WND, bus.BUSY, bus.DONE, bus.CFG_ERR, bus.ECHO_IDX};

    // Expected {ACQ_WND,BUSY,DONE,CFG_ERR,ECHO_IDX} j cycles after the accepting edge.
    function automatic logic [35:0] exp_run(int p, int d, int w, int n, int j);
        int  k, r, idx;
        logic a, b, dn;
        k   = j / p;
        r   = j % p;
        b   = (j < n * p);
        dn  = (j == n * p);
        a   = b && (r >= d + 1) && (r <= d + w);
        idx = (k < n) ? k : n - 1;
        return {a, b, dn, 1'b0, 32'(idx)};
    endfunction

    function automatic logic [35:0] idle_vec(int idx);
        return {4'b0000, 32'(idx)};
    endfunction

    task automatic drive_cfg(input logic [31:0] p, input logic [31:0] d,
                             input logic [31:0] w, input logic [31:0] n);
        bus.ECHO_PERIOD = p;
        bus.WND_DELAY   = d;
        bus.WND_WIDTH   = w;
        bus.NUM_ECHOES  = n;
    endtask

    // Leaves the bench at E0 + 1 time unit with START already dropped.
    task automatic start_run(input int p, input int d, input int w, input int n);
        drive_cfg(p, d, w, n);
        bus.START = 1'b1;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
    endtask

    task automatic test_reset();
        logic [35:0] e;
        e = '0;
        #2;
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_asserted got=%h exp=%h", obs, e); end
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_idle got=%h exp=%h", obs, e); end
    endtask

    task automatic test_basic();
        logic [35:0] e;
        start_run(10, 3, 4, 3);
        for (int j = 0; j <= 31; j++) begin
            if (j > 0) begin @(posedge CLK); #1; end
            e = exp_run(10, 3, 4, 3, j);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL basic j=%0d got=%h exp=%h", j, obs, e); end
        end
        last_idx = 2;
    endtask

    task automatic test_min_period();
        logic [35:0] e;
        start_run(2, 0, 1, 4);
        for (int j = 0; j <= 9; j++) begin
            if (j > 0) begin @(posedge CLK); #1; end
            e = exp_run(2, 0, 1, 4, j);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL min_period j=%0d got=%h exp=%h", j, obs, e); end
        end
        last_idx = 3;
    endtask

    task automatic test_cfg_err();
        logic [31:0] cp [5] = '{32'd10, 32'd10, 32'd10, 32'd5, 32'd10};
        logic [31:0] cd [5] = '{32'd5, 32'd3, 32'd3, 32'hFFFF_FFFF, 32'd9};
        logic [31:0] cw [5] = '{32'd5, 32'd4, 32'd0, 32'd2, 32'd1};
        logic [31:0] cn [5] = '{32'd3, 32'd0, 32'd3, 32'd1, 32'd1};
        logic [35:0] e;
        for (int i = 0; i < 5; i++) begin
            drive_cfg(cp[i], cd[i], cw[i], cn[i]);
            bus.START = 1'b1;
            @(posedge CLK); #1;
            bus.START = 1'b0;
            e = {4'b0001, 32'(last_idx)};
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL cfg_err_pulse%0d got=%h exp=%h", i, obs, e); end
            @(posedge CLK); #1;
            e = idle_vec(last_idx);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL cfg_err_clear%0d got=%h exp=%h", i, obs, e); end
        end
        // DELAY+WIDTH = PERIOD-1 is the tightest legal configuration.
        start_run(10, 5, 4, 2);
        for (int j = 0; j <= 21; j++) begin
            if (j > 0) begin @(posedge CLK); #1; end
            e = exp_run(10, 5, 4, 2, j);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL tight_cfg j=%0d got=%h exp=%h", j, obs, e); end
        end
        last_idx = 1;
    endtask

    task automatic test_config_latch();
        logic [35:0] e;
        start_run(10, 3, 4, 3);
        for (int j = 0; j <= 31; j++) begin
            if (j > 0) begin @(posedge CLK); #1; end
            e = exp_run(10, 3, 4, 3, j);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL config_latch j=%0d got=%h exp=%h", j, obs, e); end
            if (j == 3) drive_cfg($urandom, $urandom, $urandom, $urandom);
            bus.START = (j == 6);
        end
        bus.START = 1'b0;
        last_idx = 2;
    endtask

    task automatic test_back_to_back();
        logic [35:0] e;
        drive_cfg(10, 3, 4, 3);
        bus.START = 1'b1;
        @(posedge CLK); #1;
        for (int j = 0; j <= 30; j++) begin
            if (j > 0) begin @(posedge CLK); #1; end
            e = exp_run(10, 3, 4, 3, j);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL b2b_first j=%0d got=%h exp=%h", j, obs, e); end
            if (j == 1) drive_cfg(6, 1, 2, 2);
        end
        @(posedge CLK); #1;
        bus.START = 1'b0;
        for (int j = 0; j <= 13; j++) begin
            if (j > 0) begin @(posedge CLK); #1; end
            e = exp_run(6, 1, 2, 2, j);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL b2b_second j=%0d got=%h exp=%h", j, obs, e); end
        end
        last_idx = 1;
    endtask

    task automatic test_reset_mid_run();
        logic [35:0] e;
        start_run(10, 3, 4, 3);
        for (int j = 0; j <= 6; j++) begin
            if (j > 0) begin @(posedge CLK); #1; end
            e = exp_run(10, 3, 4, 3, j);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL pre_reset j=%0d got=%h exp=%h", j, obs, e); end
        end
        RESET = 1'b1;
        #1;
        e = '0;
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", obs, e); end
        last_idx = 0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        start_run(10, 3, 4, 3);
        for (int j = 0; j <= 31; j++) begin
            if (j > 0) begin @(posedge CLK); #1; end
            e = exp_run(10, 3, 4, 3, j);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL post_reset j=%0d got=%h exp=%h", j, obs, e); end
        end
        last_idx = 2;
    endtask

    task automatic test_random();
        int p, d, w, n, gap;
        logic [35:0] e;
        for (int it = 0; it < 12; it++) begin
            p   = int'($urandom_range(16, 2));
            w   = int'($urandom_range(p - 1, 1));
            d   = int'($urandom_range(p - 1 - w, 0));
            n   = int'($urandom_range(4, 1));
            gap = int'($urandom_range(3, 0));
            for (int g = 0; g < gap; g++) begin
                @(posedge CLK); #1;
                e = idle_vec(last_idx);
                n_checks++;
                if (obs !== e) begin n_fail++; $display("FAIL rand_idle it=%0d got=%h exp=%h", it, obs, e); end
            end
            start_run(p, d, w, n);
            for (int j = 0; j <= n * p + 1; j++) begin
                if (j > 0) begin @(posedge CLK); #1; end
                e = exp_run(p, d, w, n, j);
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL rand it=%0d p=%0d d=%0d w=%0d n=%0d j=%0d got=%h exp=%h",
                             it, p, d, w, n, j, obs, e);
                end
                if (j < n * p - 1) begin
                    bus.START = ($urandom_range(3, 0) == 0);
                    if ($urandom_range(1, 0) == 1) drive_cfg($urandom, $urandom, $urandom, $urandom);
                end else begin
                    bus.START = 1'b0;
                end
            end
            last_idx = n - 1;
        end
    endtask

`ifdef ACQ_WND_GEN_ABORT_EN
    task automatic test_abort();
        logic [35:0] e;
        start_run(10, 3, 4, 3);
        for (int j = 0; j <= 15; j++) begin
            if (j > 0) begin @(posedge CLK); #1; end
            e = exp_run(10, 3, 4, 3, j);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL pre_abort j=%0d got=%h exp=%h", j, obs, e); end
        end
        bus.ABORT = 1'b1;
        last_idx = 0;
        for (int j = 16; j <= 20; j++) begin
            @(posedge CLK); #1;
            bus.ABORT = 1'b0;
            e = idle_vec(0);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL abort j=%0d got=%h exp=%h", j, obs, e); end
        end
        start_run(10, 3, 4, 3);
        for (int j = 0; j <= 5; j++) begin
            if (j > 0) begin @(posedge CLK); #1; end
            e = exp_run(10, 3, 4, 3, j);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL pre_abort2 j=%0d got=%h exp=%h", j, obs, e); end
        end
        bus.ABORT = 1'b1;
        bus.START = 1'b1;
        @(posedge CLK); #1;
        bus.ABORT = 1'b0;
        bus.START = 1'b0;
        e = idle_vec(0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL abort_wins got=%h exp=%h", obs, e); end
        @(posedge CLK); #1;
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL abort_stays_idle got=%h exp=%h", obs, e); end
    endtask
`endif

    initial begin
        RESET     = 1'b1;
        bus.START = 1'b0;
        drive_cfg(0, 0, 0, 0);
`ifdef ACQ_WND_GEN_ABORT_EN
        bus.ABORT = 1'b0;
`endif
        test_reset();
        test_basic();
        test_cfg_err();
        test_min_period();
        test_config_latch();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
`ifdef ACQ_WND_GEN_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
